// File: rtl/bank_sel_pair_flag_pipe_pkg.sv
// Shared constants and index helpers for the bank-select pair flag pipeline.
package bank_flag_pkg;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_GROUP  = 2;
    localparam int unsigned DEF_CNT_W  = 8;

    function automatic int unsigned num_grp(input int unsigned nch, input int unsigned grp);
        return nch / grp;
    endfunction

    // Low bit of the two-bit pair owned by channel c in a packed bank word.
    function automatic int unsigned ch_lo(input int unsigned c);
        return 2 * c;
    endfunction

    // LSB of counter c in the packed hit_cnt bus.
    function automatic int unsigned cnt_lo(input int unsigned c, input int unsigned cnt_w);
        return c * cnt_w;
    endfunction

endpackage

// File: rtl/bank_sel_pair_flag_pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/bank_sel_pair_flag_pipe.sv
// Two-stage pipelined bank-select pair-AND flag network with per-channel hit counters.
module bank_sel_pair_flag_pipe
    import bank_flag_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned GROUP  = DEF_GROUP,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      bank_sel,
    input  logic [2*NUM_CH-1:0]       bank_a,
    input  logic [2*NUM_CH-1:0]       bank_b,
    input  logic                      cnt_clr,
    output logic                      out_valid,
    output logic [NUM_CH-1:0]         ch_flag,
    output logic [num_grp(NUM_CH, GROUP)-1:0] grp_any,
    output logic                      summary,
    output logic [NUM_CH*CNT_W-1:0]   hit_cnt
);

    localparam int unsigned NUM_GRP = num_grp(NUM_CH, GROUP);

    logic [2*NUM_CH-1:0] r_s1_sel;
    logic                r_s1_valid;

    logic [NUM_CH-1:0]   w_flag;
    logic [NUM_GRP-1:0]  w_grp;
    logic                w_summary;

    logic                r_out_valid;
    logic [NUM_CH-1:0]   r_ch_flag;
    logic [NUM_GRP-1:0]  r_grp_any;
    logic                r_summary;

    // Stage 1: the select is applied here so bank_sel travels with its data word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_sel   <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_sel   <= bank_sel ? bank_b : bank_a;
            r_s1_valid <= in_valid;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_flag
        assign w_flag[c] = r_s1_sel[ch_lo(c)] & r_s1_sel[ch_lo(c) + 1];
    end

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        assign w_grp[g] = |w_flag[g*GROUP +: GROUP];
    end

    assign w_summary = ~&w_grp;

    // Stage 2: all outputs load together so they always describe the same word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_ch_flag   <= '0;
            r_grp_any   <= '0;
            r_summary   <= 1'b1;
        end else begin
            r_out_valid <= r_s1_valid;
            r_ch_flag   <= w_flag;
            r_grp_any   <= w_grp;
            r_summary   <= w_summary;
        end
    end

    assign out_valid = r_out_valid;
    assign ch_flag   = r_ch_flag;
    assign grp_any   = r_grp_any;
    assign summary   = r_summary;

    // Counters count the word being loaded into stage 2, hence the stage-1 terms.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
        logic [CNT_W-1:0] w_count;

        sat_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (r_s1_valid & w_flag[c]),
            .clr  (cnt_clr),
            .count(w_count)
        );

        assign hit_cnt[cnt_lo(c, CNT_W) +: CNT_W] = w_count;
    end

endmodule

// File: tb/tb_bank_sel_pair_flag_pipe.sv
// Directed self-checking bench for bank_sel_pair_flag_pipe (4 channels, groups of 2, 8-bit counters).
module tb_bank_sel_pair_flag_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        bank_sel;
    logic [7:0]  bank_a;
    logic [7:0]  bank_b;
    logic        cnt_clr;
    logic        out_valid;
    logic [3:0]  ch_flag;
    logic [1:0]  grp_any;
    logic        summary;
    logic [31:0] hit_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bank_sel_pair_flag_pipe #(
        .NUM_CH(4),
        .GROUP (2),
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .bank_sel (bank_sel),
        .bank_a   (bank_a),
        .bank_b   (bank_b),
        .cnt_clr  (cnt_clr),
        .out_valid(out_valid),
        .ch_flag  (ch_flag),
        .grp_any  (grp_any),
        .summary  (summary),
        .hit_cnt  (hit_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [3:0] cf,
                             input logic [1:0] ga, input logic sm);
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        check({tag, ".ch_flag"},   {28'd0, ch_flag},   {28'd0, cf});
        check({tag, ".grp_any"},   {30'd0, grp_any},   {30'd0, ga});
        check({tag, ".summary"},   {31'd0, summary},   {31'd0, sm});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; bank_sel = 1'b0;
        bank_a = '0; bank_b = '0; cnt_clr = 1'b0;

        // 1: reset held, then released with no valid input
        repeat (3) step();
        check_out("rst_hold", 1'b0, 4'b0000, 2'b00, 1'b1);
        check("rst_hold.hit_cnt", hit_cnt, 32'h0);
        rst = 1'b0;
        step(); step();
        check_out("idle", 1'b0, 4'b0000, 2'b00, 1'b1);

        // 2: single valid word on bank A
        bank_a = 8'b11_00_00_11; bank_b = 8'h00; bank_sel = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_out("bankA", 1'b1, 4'b1001, 2'b11, 1'b0);
        check("bankA.hit_cnt", hit_cnt, {8'd1, 8'd0, 8'd0, 8'd1});
        step();
        check("bankA.drain_valid", {31'd0, out_valid}, 32'd0);

        // 3: alternating bank_sel back-to-back
        in_valid = 1'b1; bank_sel = 1'b1; step();
        bank_sel = 1'b0; step();
        check_out("alt0", 1'b1, 4'b0000, 2'b00, 1'b1);
        bank_sel = 1'b1; step();
        check_out("alt1", 1'b1, 4'b1001, 2'b11, 1'b0);
        bank_sel = 1'b0; step();
        check_out("alt2", 1'b1, 4'b0000, 2'b00, 1'b1);
        in_valid = 1'b0; step();
        check_out("alt3", 1'b1, 4'b1001, 2'b11, 1'b0);
        step();
        check("alt.drain_valid", {31'd0, out_valid}, 32'd0);
        check("alt.hit_cnt", hit_cnt, {8'd3, 8'd0, 8'd0, 8'd3});

        // 4: saturation, then clear colliding with a hit
        bank_a = 8'hFF; bank_sel = 1'b0; in_valid = 1'b1;
        repeat (300) step();
        check("sat.hit_cnt", hit_cnt, {8'd255, 8'd255, 8'd255, 8'd255});
        check_out("sat", 1'b1, 4'b1111, 2'b11, 1'b0);
        cnt_clr = 1'b1; step();
        check("clr.hit_cnt", hit_cnt, 32'h0);
        cnt_clr = 1'b0; step();
        check("post_clr.hit_cnt", hit_cnt, {8'd1, 8'd1, 8'd1, 8'd1});
        in_valid = 1'b0; step(); step();
        check("drain.hit_cnt", hit_cnt, {8'd2, 8'd2, 8'd2, 8'd2});

        // 5: reset lands while a valid word is in stage 1
        in_valid = 1'b1; step();
        in_valid = 1'b0; rst = 1'b1; step();
        check_out("mid_rst", 1'b0, 4'b0000, 2'b00, 1'b1);
        check("mid_rst.hit_cnt", hit_cnt, 32'h0);
        rst = 1'b0; step();
        check_out("post_rst", 1'b0, 4'b0000, 2'b00, 1'b1);

        // 6: single channel hit, then the same data marked invalid
        bank_a = 8'b00_00_11_00; bank_sel = 1'b0; in_valid = 1'b1; step();
        in_valid = 1'b0; step();
        check_out("ch1", 1'b1, 4'b0010, 2'b01, 1'b1);
        check("ch1.hit_cnt", hit_cnt, {8'd0, 8'd0, 8'd1, 8'd0});
        step(); step();
        check_out("ch1_invalid", 1'b0, 4'b0010, 2'b01, 1'b1);
        check("ch1_invalid.hit_cnt", hit_cnt, {8'd0, 8'd0, 8'd1, 8'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
